// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Provides the default address/instruction widths, the fetch step and
// the word-alignment width, plus the per-cycle response classification.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

package fetch_unit_pkg;

   // Default widths, taken from the codebase-wide defines
   localparam int ADDR_SIZE_DEF  = `ADDR_SIZE;
   localparam int INSTR_SIZE_DEF = `INSTR_SIZE;

   // Byte distance between consecutive instructions
   localparam int INSTR_STEP = 4;

   // Number of low PC bits that are always zero for word-aligned fetch
   localparam int ALIGN_BITS = 2;

   // What happens to an instruction-memory response in a given cycle
   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,  // no response this cycle
      RSP_KEEP = 2'd1,  // response belongs to the live stream
      RSP_DROP = 2'd2   // response belongs to a stream cancelled by a redirect
   } rspAction_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO used for both the in-flight PC queue and the
// prefetch queue. Head data is read straight from the storage array, so it
// is valid whenever empty is low. flush has priority over push and pop;
// push while full is accepted only when a pop happens in the same cycle.

module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             pushData,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             headData,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
   endfunction

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign doPop    = pop && !empty;
   assign doPush   = push && !flush && (!full || doPop);
   assign headData = mem[rdPtr];

   // Pointer and occupancy bookkeeping
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array write port
   // NOTE: the data array has no reset; entries are only read once count marks them valid.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch front end.
// Issues word-aligned requests to a variable-latency, in-order instruction
// memory, pairs each response with its request PC and buffers the result
// in a prefetch queue that decode drains with a valid/ready handshake.
// A redirect flushes both queues and arms a counter that discards the
// responses still in flight for the cancelled stream.
// Optional build macro FETCH_PERF_CNT_EN adds three free-running 32-bit
// counters: instructions delivered, redirects taken, responses discarded.

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                   ADDR_SIZE       = ADDR_SIZE_DEF,
   parameter int                   INSTR_SIZE      = INSTR_SIZE_DEF,
   parameter int                   FIFO_DEPTH      = 4,
   parameter int                   MAX_OUTSTANDING = 2,
   parameter logic [ADDR_SIZE-1:0] RESET_PC        = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_SIZE-1:0]  imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INSTR_SIZE-1:0] imem_rsp_instr,
   input  logic                  redirect_valid,
   input  logic [ADDR_SIZE-1:0]  redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_SIZE-1:0]  out_pc,
   output logic [INSTR_SIZE-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_redirects,
   output logic [31:0]           perf_dropped
`endif
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PF_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PF_W = ADDR_SIZE + INSTR_SIZE;

   logic [ADDR_SIZE-1:0] fetchPc;
   logic [OUT_W-1:0]     dropCnt;
   logic [OUT_W-1:0]     outstanding;
   logic [OUT_W-1:0]     dropAfterRedirect;
   logic                 creditOk;
   logic                 reqFire;
   logic                 popFire;
   rspAction_t           rspAction;

   // In-flight PC queue signals
   logic [ADDR_SIZE-1:0] pcHead;
   logic                 pcFull;
   logic                 pcEmpty;
   logic [OUT_W-1:0]     pcCount;

   // Prefetch queue signals
   logic [PF_W-1:0]      pfHead;
   logic                 pfFull;
   logic                 pfEmpty;
   logic [PF_CNT_W-1:0]  pfCount;

   logic                 unusedBits;

   // Every request is either waiting in the PC queue (live stream) or is a
   // cancelled one that the drop counter will swallow, so the sum is the
   // total number of requests the memory still owes us.
   assign outstanding = pcCount + dropCnt;

   // A fetch may start only if both the memory credit and the space left in
   // the prefetch queue (counting everything already on its way) allow it.
   assign creditOk = (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                     ((32'(outstanding) + 32'(pfCount)) < 32'(FIFO_DEPTH));

   // Gated by rst so the port reads 0 throughout reset, not only after it.
   assign imem_req_valid = rst && !redirect_valid && creditOk;
   assign imem_req_addr  = fetchPc;
   assign reqFire        = imem_req_valid && imem_req_ready;
   assign popFire        = out_valid && out_ready;

   // After a redirect every request still owed by memory is stale, except a
   // response arriving in the redirect cycle itself, which is discarded on
   // the spot whether it was live or already marked for dropping.
   assign dropAfterRedirect = (imem_rsp_valid && (outstanding != '0)) ?
                              outstanding - 1'b1 : outstanding;

   // Classify the response of this cycle as kept, dropped or absent
   // NOTE: combinational outputs get a default first so no path can infer a latch.
   always_comb begin
      rspAction = RSP_NONE;
      if (imem_rsp_valid) begin
         rspAction = (redirect_valid || (dropCnt != '0)) ? RSP_DROP : RSP_KEEP;
      end
   end

   // Fetch PC and stale-response counter; redirect overrides everything else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchPc <= RESET_PC;
         dropCnt <= '0;
      end else if (redirect_valid) begin
         fetchPc <= {redirect_pc[ADDR_SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
         dropCnt <= dropAfterRedirect;
      end else begin
         if (reqFire) fetchPc <= fetchPc + ADDR_SIZE'(INSTR_STEP);
         if (rspAction == RSP_DROP) dropCnt <= dropCnt - 1'b1;
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_SIZE),
      .DEPTH (MAX_OUTSTANDING)
   ) u_inflightQ (
      .clk      (clk),
      .rst      (rst),
      .push     (reqFire),
      .pushData (fetchPc),
      .pop      (rspAction == RSP_KEEP),
      .flush    (redirect_valid),
      .headData (pcHead),
      .full     (pcFull),
      .empty    (pcEmpty),
      .count    (pcCount)
   );

   fetch_fifo #(
      .WIDTH (PF_W),
      .DEPTH (FIFO_DEPTH)
   ) u_prefetchQ (
      .clk      (clk),
      .rst      (rst),
      .push     (rspAction == RSP_KEEP),
      .pushData ({pcHead, imem_rsp_instr}),
      .pop      (popFire),
      .flush    (redirect_valid),
      .headData (pfHead),
      .full     (pfFull),
      .empty    (pfEmpty),
      .count    (pfCount)
   );

   // Head fields come straight from queue storage; masked while empty so
   // the outputs read 0 out of reset and after a flush.
   assign out_valid = !pfEmpty;
   assign out_pc    = pfEmpty ? '0 : pfHead[PF_W-1 -: ADDR_SIZE];
   assign out_instr = pfEmpty ? '0 : pfHead[INSTR_SIZE-1:0];

   // Status flags and ignored PC bits that the credit scheme makes redundant
   assign unusedBits = ^{pcFull, pcEmpty, pfFull, redirect_pc[ALIGN_BITS-1:0]};

`ifdef FETCH_PERF_CNT_EN
   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
         perf_dropped   <= '0;
      end else begin
         if (popFire)                perf_fetched   <= perf_fetched + 32'd1;
         if (redirect_valid)         perf_redirects <= perf_redirects + 32'd1;
         if (rspAction == RSP_DROP)  perf_dropped   <= perf_dropped + 32'd1;
      end
   end
`endif

endmodule
